pwr_rail_seq_n: RTL and testbench

//  Generic N-rail power sequencer, successor to the fixed AUX/FAN/NODE master sequencer.

---
 rtl/pwr_rail_seq_n.sv | 201 ++++++++++++++++++++
 tb/tb_pwr_rail_seq_n.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_rail_seq_n.sv
// Generic N-rail power sequencer: ordered power-up with per-rail on-delay and PG timeout,
// reverse-order power-down, runtime PG-loss, sequence-timeout and emergency fault latching.
module pwr_rail_seq_n #(
    parameter int unsigned NUM_RAILS     = 4,
    parameter int unsigned DLY_W         = 16,
    parameter int unsigned PG_TIMEOUT_MS = 10000,
    parameter int unsigned OFF_DLY_MS    = 10
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iTick_1ms,
    input  logic                       iPwr_Req,
    input  logic                       iEmerg_Off,
    input  logic                       iClear_Flt,
    input  logic [NUM_RAILS-1:0]       iPWRGD,
    input  logic [NUM_RAILS*DLY_W-1:0] iOn_Dly,
    output logic [NUM_RAILS-1:0]       oRail_EN,
    output logic                       oAll_PWRGD,
    output logic                       oSeq_Busy,
    output logic [NUM_RAILS-1:0]       oSEQPWR_FLT_N,
    output logic [NUM_RAILS-1:0]       oRUNTIME_FLT_N,
    output logic                       oEMERG_FLT_N,
    output logic [3:0]                 oDBG_FSM_curr
);

    localparam int unsigned      IDX_W    = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [DLY_W-1:0] PG_TO    = DLY_W'(PG_TIMEOUT_MS);
    localparam logic [DLY_W-1:0] OFF_TO   = DLY_W'(OFF_DLY_MS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'h9,
        ON_DLY  = 4'h7,
        ON_PG   = 4'h5,
        UP      = 4'h0,
        OFF_DLY = 4'h3,
        FAULT   = 4'hF
    } stateT;

    stateT                state;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     hiIdx;
    logic [DLY_W-1:0]     cnt;
    logic [DLY_W-1:0]     onDlySel;
    logic [NUM_RAILS-1:0] pgMeta;
    logic [NUM_RAILS-1:0] pgSync;
    logic [NUM_RAILS-1:0] watchMask;
    logic [NUM_RAILS-1:0] rtFault;
    logic [NUM_RAILS-1:0] railEn;
    logic [NUM_RAILS-1:0] seqFltN;
    logic [NUM_RAILS-1:0] runtimeFltN;
    logic                 emergFltN;
    logic                 allPwrgd;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pgMeta <= '0;
            pgSync <= '0;
        end else begin
            pgMeta <= iPWRGD;
            pgSync <= pgMeta;
        end
    end

    always_comb begin
        onDlySel = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++)
            if (IDX_W'(i) == idx) onDlySel = iOn_Dly[i*DLY_W +: DLY_W];
    end

    // Rails below idx have already proven good; in UP every rail is watched.
    always_comb begin
        watchMask = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++)
            watchMask[i] = (state == UP) || (IDX_W'(i) < idx);
    end

    assign rtFault = watchMask & ~pgSync;

    always_comb begin
        hiIdx = '0;
        for (int unsigned i = 0; i < NUM_RAILS; i++)
            if (railEn[i]) hiIdx = IDX_W'(i);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            railEn      <= '0;
            seqFltN     <= '1;
            runtimeFltN <= '1;
            emergFltN   <= 1'b1;
            allPwrgd    <= 1'b0;
        end else begin
            allPwrgd <= 1'b0;
            if (iTick_1ms && cnt != '1) cnt <= cnt + 1'b1;

            if (iEmerg_Off && state != FAULT) begin
                railEn    <= '0;
                emergFltN <= 1'b0;
                state     <= FAULT;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iPwr_Req) begin
                            idx   <= '0;
                            cnt   <= '0;
                            state <= ON_DLY;
                        end
                    end

                    ON_DLY, ON_PG, UP: begin
                        if (|rtFault) begin
                            runtimeFltN <= runtimeFltN & ~rtFault;
                            railEn      <= '0;
                            cnt         <= '0;
                            state       <= FAULT;
                        end else if (state == ON_PG && cnt >= PG_TO) begin
                            seqFltN[idx] <= 1'b0;
                            railEn       <= '0;
                            cnt          <= '0;
                            state        <= FAULT;
                        end else if (!iPwr_Req) begin
                            // Highest enabled rail drops on this edge; idx then names the next one.
                            cnt <= '0;
                            if (!(|railEn)) begin
                                state <= IDLE;
                            end else begin
                                railEn[hiIdx] <= 1'b0;
                                if (hiIdx == '0) begin
                                    state <= IDLE;
                                end else begin
                                    idx   <= hiIdx - 1'b1;
                                    state <= OFF_DLY;
                                end
                            end
                        end else if (state == ON_DLY) begin
                            if (cnt >= onDlySel) begin
                                railEn[idx] <= 1'b1;
                                cnt         <= '0;
                                state       <= ON_PG;
                            end
                        end else if (state == ON_PG) begin
                            if (pgSync[idx]) begin
                                cnt <= '0;
                                if (idx == LAST_IDX) begin
                                    state <= UP;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= ON_DLY;
                                end
                            end
                        end else begin
                            allPwrgd <= 1'b1;
                        end
                    end

                    OFF_DLY: begin
                        if (cnt >= OFF_TO) begin
                            railEn[idx] <= 1'b0;
                            cnt         <= '0;
                            if (idx == '0) state <= IDLE;
                            else           idx   <= idx - 1'b1;
                        end
                    end

                    FAULT: begin
                        railEn <= '0;
                        if (iClear_Flt && !iPwr_Req && !iEmerg_Off) begin
                            seqFltN     <= '1;
                            runtimeFltN <= '1;
                            emergFltN   <= 1'b1;
                            idx         <= '0;
                            cnt         <= '0;
                            state       <= IDLE;
                        end
                    end

                    default: begin
                        railEn <= '0;
                        idx    <= '0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign oRail_EN       = railEn;
    assign oAll_PWRGD     = allPwrgd;
    assign oSeq_Busy      = (state == ON_DLY) || (state == ON_PG) || (state == OFF_DLY);
    assign oSEQPWR_FLT_N  = seqFltN;
    assign oRUNTIME_FLT_N = runtimeFltN;
    assign oEMERG_FLT_N   = emergFltN;
    assign oDBG_FSM_curr  = state;

endmodule

// File: tb/tb_pwr_rail_seq_n.sv
// Directed bench for pwr_rail_seq_n: 4 rails, fast 1ms tick (every 4 clocks), PG model answering each enable.
module tb_pwr_rail_seq_n;

    logic        iClk        = 1'b0;
    logic        iRst_n      = 1'b0;
    logic        iTick_1ms   = 1'b0;
    logic        iPwr_Req    = 1'b0;
    logic        iEmerg_Off  = 1'b0;
    logic        iClear_Flt  = 1'b0;
    logic [3:0]  iPWRGD;
    logic [63:0] iOn_Dly     = {16'd20, 16'd10, 16'd5, 16'd0};
    logic [3:0]  oRail_EN;
    logic        oAll_PWRGD;
    logic        oSeq_Busy;
    logic [3:0]  oSEQPWR_FLT_N;
    logic [3:0]  oRUNTIME_FLT_N;
    logic        oEMERG_FLT_N;
    logic [3:0]  oDBG_FSM_curr;

    logic [3:0]  pgAuto    = '0;
    logic [3:0]  pgSeen    = '0;
    logic [3:0]  pgKill    = '0;
    int          tickDiv   = 0;
    int          tickCount = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    assign iPWRGD = pgAuto & ~pgKill;

    pwr_rail_seq_n #(
        .NUM_RAILS    (4),
        .DLY_W        (16),
        .PG_TIMEOUT_MS(10000),
        .OFF_DLY_MS   (10)
    ) dut (
        .iClk          (iClk),
        .iRst_n        (iRst_n),
        .iTick_1ms     (iTick_1ms),
        .iPwr_Req      (iPwr_Req),
        .iEmerg_Off    (iEmerg_Off),
        .iClear_Flt    (iClear_Flt),
        .iPWRGD        (iPWRGD),
        .iOn_Dly       (iOn_Dly),
        .oRail_EN      (oRail_EN),
        .oAll_PWRGD    (oAll_PWRGD),
        .oSeq_Busy     (oSeq_Busy),
        .oSEQPWR_FLT_N (oSEQPWR_FLT_N),
        .oRUNTIME_FLT_N(oRUNTIME_FLT_N),
        .oEMERG_FLT_N  (oEMERG_FLT_N),
        .oDBG_FSM_curr (oDBG_FSM_curr)
    );

    always #5 iClk = ~iClk;

    // PG goes high on the second tick seen after its enable, and low as soon as the enable drops.
    always @(negedge iClk) begin
        for (int i = 0; i < 4; i++) begin
            if (!oRail_EN[i]) begin
                pgAuto[i] = 1'b0;
                pgSeen[i] = 1'b0;
            end else if (iTick_1ms) begin
                if (pgSeen[i]) pgAuto[i] = 1'b1;
                pgSeen[i] = 1'b1;
            end
        end
        tickDiv   = (tickDiv == 3) ? 0 : tickDiv + 1;
        iTick_1ms = (tickDiv == 0);
        if (iTick_1ms) tickCount++;
    end

    task automatic waitEn(input logic [3:0] mask, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (oRail_EN === mask) break;
            @(posedge iClk); #1;
        end
    endtask

    task automatic waitState(input logic [3:0] code, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (oDBG_FSM_curr === code) break;
            @(posedge iClk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge iClk);
        #1;
        vectors++;
        if ({oRail_EN, oAll_PWRGD, oSeq_Busy} !== 6'b0) begin
            $display("FAIL reset_outs: got %b, want 000000", {oRail_EN, oAll_PWRGD, oSeq_Busy});
            miscompares++;
        end
        vectors++;
        if ({oSEQPWR_FLT_N, oRUNTIME_FLT_N, oEMERG_FLT_N} !== 9'h1FF) begin
            $display("FAIL reset_flags: got %h, want 1ff", {oSEQPWR_FLT_N, oRUNTIME_FLT_N, oEMERG_FLT_N});
            miscompares++;
        end
        @(negedge iClk) iRst_n = 1'b1;
        @(posedge iClk); #1;
        vectors++;
        if (oDBG_FSM_curr !== 4'h9) begin
            $display("FAIL reset_state: got %h, want 9", oDBG_FSM_curr);
            miscompares++;
        end
    endtask

    task automatic test_power_up;
        int dly[4] = '{0, 5, 10, 20};
        int t, gap, n;
        logic [3:0] mask;
        @(negedge iClk) iPwr_Req = 1'b1;
        waitEn(4'b0001, 4);
        vectors++;
        if (oRail_EN !== 4'b0001) begin
            $display("FAIL up_en0_zero_dly: got %b, want 0001", oRail_EN);
            miscompares++;
        end
        t = tickCount;
        for (int i = 1; i < 4; i++) begin
            mask = 4'((1 << (i + 1)) - 1);
            waitEn(mask, 200);
            vectors++;
            if (oRail_EN !== mask) begin
                $display("FAIL up_en_order[%0d]: got %b, want %b", i, oRail_EN, mask);
                miscompares++;
            end
            gap = tickCount - t;
            vectors++;
            if (gap < dly[i] + 1 || gap > dly[i] + 3) begin
                $display("FAIL up_gap[%0d]: got %0d ms, want %0d..%0d ms", i, gap, dly[i] + 1, dly[i] + 3);
                miscompares++;
            end
            t = tickCount;
        end
        vectors++;
        if ({oDBG_FSM_curr, oSeq_Busy} !== {4'h5, 1'b1}) begin
            $display("FAIL up_onpg_busy: got %h/%b, want 5/1", oDBG_FSM_curr, oSeq_Busy);
            miscompares++;
        end
        for (int c = 0; c < 20; c++) begin
            if (iPWRGD[3]) break;
            @(posedge iClk); #1;
        end
        n = 0;
        while (!oAll_PWRGD && n < 10) begin
            @(posedge iClk); #1;
            n++;
        end
        vectors++;
        if (oAll_PWRGD !== 1'b1 || n < 2 || n > 3) begin
            $display("FAIL up_allpwrgd: got %b after %0d cycles, want 1 after 2..3", oAll_PWRGD, n);
            miscompares++;
        end
        vectors++;
        if ({oDBG_FSM_curr, oSeq_Busy} !== {4'h0, 1'b0}) begin
            $display("FAIL up_state: got %h/%b, want 0/0", oDBG_FSM_curr, oSeq_Busy);
            miscompares++;
        end
    endtask

    task automatic test_power_down;
        logic [3:0] masks[3] = '{4'b0011, 4'b0001, 4'b0000};
        int t, gap;
        @(negedge iClk) iPwr_Req = 1'b0;
        @(posedge iClk); #1;
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr, oSeq_Busy, oAll_PWRGD} !== {4'b0111, 4'h3, 1'b1, 1'b0}) begin
            $display("FAIL dn_first: got %b/%h/%b/%b, want 0111/3/1/0", oRail_EN, oDBG_FSM_curr, oSeq_Busy, oAll_PWRGD);
            miscompares++;
        end
        t = tickCount;
        for (int i = 0; i < 3; i++) begin
            waitEn(masks[i], 80);
            gap = tickCount - t;
            vectors++;
            if (oRail_EN !== masks[i] || gap < 10 || gap > 11) begin
                $display("FAIL dn_step[%0d]: got %b after %0d ms, want %b after 10..11 ms", i, oRail_EN, gap, masks[i]);
                miscompares++;
            end
            t = tickCount;
        end
        vectors++;
        if ({oDBG_FSM_curr, oSeq_Busy} !== {4'h9, 1'b0}) begin
            $display("FAIL dn_idle: got %h/%b, want 9/0", oDBG_FSM_curr, oSeq_Busy);
            miscompares++;
        end
    endtask

    task automatic test_runtime;
        @(negedge iClk) iPwr_Req = 1'b1;
        waitState(4'h0, 800);
        vectors++;
        if (oDBG_FSM_curr !== 4'h0) begin
            $display("FAIL rt_reach_up: got %h, want 0", oDBG_FSM_curr);
            miscompares++;
        end
        @(negedge iClk) pgKill[1] = 1'b1;
        repeat (3) @(negedge iClk);
        pgKill[1] = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oRail_EN, oRUNTIME_FLT_N} !== {4'hF, 4'b0000, 4'b1101}) begin
            $display("FAIL rt_fault: got %h/%b/%b, want f/0000/1101", oDBG_FSM_curr, oRail_EN, oRUNTIME_FLT_N);
            miscompares++;
        end
        vectors++;
        if ({oSEQPWR_FLT_N, oEMERG_FLT_N, oAll_PWRGD} !== 6'b111110) begin
            $display("FAIL rt_other_flags: got %b, want 111110", {oSEQPWR_FLT_N, oEMERG_FLT_N, oAll_PWRGD});
            miscompares++;
        end
        @(negedge iClk);
        iPwr_Req   = 1'b0;
        iClear_Flt = 1'b1;
        @(negedge iClk) iClear_Flt = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oRUNTIME_FLT_N} !== {4'h9, 4'hF}) begin
            $display("FAIL rt_clear: got %h/%b, want 9/1111", oDBG_FSM_curr, oRUNTIME_FLT_N);
            miscompares++;
        end
    endtask

    task automatic test_timeout;
        int t, gap;
        @(negedge iClk);
        pgKill[2] = 1'b1;
        iPwr_Req  = 1'b1;
        waitEn(4'b0111, 400);
        vectors++;
        if (oRail_EN !== 4'b0111) begin
            $display("FAIL to_en2: got %b, want 0111", oRail_EN);
            miscompares++;
        end
        t = tickCount;
        waitState(4'hF, 40100);
        gap = tickCount - t;
        vectors++;
        if (oDBG_FSM_curr !== 4'hF || gap < 10000 || gap > 10001) begin
            $display("FAIL to_expiry: got state %h after %0d ms, want f after 10000..10001 ms", oDBG_FSM_curr, gap);
            miscompares++;
        end
        vectors++;
        if ({oSEQPWR_FLT_N, oRail_EN, oRUNTIME_FLT_N, oSeq_Busy} !== {4'b1011, 4'b0000, 4'b1111, 1'b0}) begin
            $display("FAIL to_flags: got %b/%b/%b/%b, want 1011/0000/1111/0", oSEQPWR_FLT_N, oRail_EN, oRUNTIME_FLT_N, oSeq_Busy);
            miscompares++;
        end
        @(negedge iClk) iClear_Flt = 1'b1;
        @(negedge iClk) iClear_Flt = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oSEQPWR_FLT_N} !== {4'hF, 4'b1011}) begin
            $display("FAIL to_clear_blocked_by_req: got %h/%b, want f/1011", oDBG_FSM_curr, oSEQPWR_FLT_N);
            miscompares++;
        end
        @(negedge iClk);
        iPwr_Req   = 1'b0;
        pgKill[2]  = 1'b0;
        iClear_Flt = 1'b1;
        @(negedge iClk) iClear_Flt = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oSEQPWR_FLT_N} !== {4'h9, 4'hF}) begin
            $display("FAIL to_clear: got %h/%b, want 9/1111", oDBG_FSM_curr, oSEQPWR_FLT_N);
            miscompares++;
        end
    endtask

    task automatic test_emergency;
        @(negedge iClk);
        pgKill[1] = 1'b1;
        iPwr_Req  = 1'b1;
        waitEn(4'b0011, 200);
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr} !== {4'b0011, 4'h5}) begin
            $display("FAIL em_onpg_idx1: got %b/%h, want 0011/5", oRail_EN, oDBG_FSM_curr);
            miscompares++;
        end
        repeat (12) @(negedge iClk);
        pgKill[1] = 1'b0;
        // Synced PG[1] is seen on the third rising edge after release; emergency lands on that same edge.
        repeat (2) @(negedge iClk);
        iEmerg_Off = 1'b1;
        @(posedge iClk); #1;
        vectors++;
        if ({oDBG_FSM_curr, oRail_EN, oEMERG_FLT_N} !== {4'hF, 4'b0000, 1'b0}) begin
            $display("FAIL em_fault: got %h/%b/%b, want f/0000/0", oDBG_FSM_curr, oRail_EN, oEMERG_FLT_N);
            miscompares++;
        end
        vectors++;
        if ({oSEQPWR_FLT_N, oRUNTIME_FLT_N} !== 8'hFF) begin
            $display("FAIL em_rail_flags: got %h, want ff", {oSEQPWR_FLT_N, oRUNTIME_FLT_N});
            miscompares++;
        end
        @(negedge iClk);
        iPwr_Req   = 1'b0;
        iClear_Flt = 1'b1;
        @(negedge iClk) iClear_Flt = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oEMERG_FLT_N} !== {4'hF, 1'b0}) begin
            $display("FAIL em_clear_blocked: got %h/%b, want f/0", oDBG_FSM_curr, oEMERG_FLT_N);
            miscompares++;
        end
        @(negedge iClk);
        iEmerg_Off = 1'b0;
        iClear_Flt = 1'b1;
        @(negedge iClk) iClear_Flt = 1'b0;
        #1;
        vectors++;
        if ({oDBG_FSM_curr, oEMERG_FLT_N} !== {4'h9, 1'b1}) begin
            $display("FAIL em_clear: got %h/%b, want 9/1", oDBG_FSM_curr, oEMERG_FLT_N);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back;
        int t, gap;
        @(negedge iClk) iPwr_Req = 1'b1;
        waitEn(4'b0011, 200);
        waitState(4'h7, 40);
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr} !== {4'b0011, 4'h7}) begin
            $display("FAIL bb_ondly_idx2: got %b/%h, want 0011/7", oRail_EN, oDBG_FSM_curr);
            miscompares++;
        end
        repeat (8) @(negedge iClk);
        iPwr_Req = 1'b0;
        @(posedge iClk); #1;
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr} !== {4'b0001, 4'h3}) begin
            $display("FAIL bb_first_off: got %b/%h, want 0001/3", oRail_EN, oDBG_FSM_curr);
            miscompares++;
        end
        t = tickCount;
        repeat (6) @(negedge iClk);
        iPwr_Req = 1'b1;
        waitEn(4'b0000, 80);
        gap = tickCount - t;
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr} !== {4'b0000, 4'h9} || gap < 10 || gap > 11) begin
            $display("FAIL bb_to_idle: got %b/%h after %0d ms, want 0000/9 after 10..11 ms", oRail_EN, oDBG_FSM_curr, gap);
            miscompares++;
        end
        @(posedge iClk); #1;
        vectors++;
        if (oDBG_FSM_curr !== 4'h7) begin
            $display("FAIL bb_restart: got %h, want 7", oDBG_FSM_curr);
            miscompares++;
        end
        waitEn(4'b0001, 4);
        vectors++;
        if (oRail_EN !== 4'b0001) begin
            $display("FAIL bb_restart_en0: got %b, want 0001", oRail_EN);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid;
        waitEn(4'b0011, 200);
        #2 iRst_n = 1'b0;
        #1;
        vectors++;
        if ({oRail_EN, oDBG_FSM_curr} !== {4'b0000, 4'h9}) begin
            $display("FAIL rst_async_en: got %b/%h, want 0000/9", oRail_EN, oDBG_FSM_curr);
            miscompares++;
        end
        @(negedge iClk);
        iRst_n     = 1'b1;
        iEmerg_Off = 1'b1;
        @(posedge iClk); #1;
        vectors++;
        if (oEMERG_FLT_N !== 1'b0) begin
            $display("FAIL rst_emerg_latch: got %b, want 0", oEMERG_FLT_N);
            miscompares++;
        end
        #2 iRst_n = 1'b0;
        #1;
        vectors++;
        if ({oEMERG_FLT_N, oDBG_FSM_curr} !== {1'b1, 4'h9}) begin
            $display("FAIL rst_async_flags: got %b/%h, want 1/9", oEMERG_FLT_N, oDBG_FSM_curr);
            miscompares++;
        end
        iEmerg_Off = 1'b0;
        iPwr_Req   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_runtime();
        test_timeout();
        test_emergency();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
